// File: rtl/simd_vec_engine_if.sv
// BRAM port-B bundle between the vector engine (master) and the block RAM (slave).
// addrb is a byte address; web is all-ones for a 32-bit write.
interface simd_vec_engine_if;
  logic [31:0] addrb;
  logic [31:0] dinb;
  logic [31:0] doutb;
  logic        enb;
  logic [3:0]  web;

  modport master (output addrb, output dinb, output enb, output web, input doutb);
  modport slave  (input addrb, input dinb, input enb, input web, output doutb);
endinterface

// File: rtl/simd_vec_engine.sv
// Instruction-driven SIMD engine: LANES lanes of unsigned multiply-accumulate,
// with operand loads and result stores over BRAM port B.
module simd_vec_engine #(
  parameter int LANES    = 4,
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 64,
  parameter int BRAM_LAT = 2,
  parameter int N        = 512
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 START_SIGNAL,
  output logic                 STOP_SIGNAL,
  input  logic [31:0]          INSTR_AXI,
  output logic [$clog2(N)-1:0] PC_AXI,
  simd_vec_engine_if.master    bram
);
  localparam int PC_W  = $clog2(N);
  localparam int CNT_W = $clog2(LANES + BRAM_LAT + 1);

  typedef enum logic [2:0] {
    OP_NOP, OP_CLR, OP_LOADA, OP_LOADB, OP_MAC, OP_STORE, OP_STOP, OP_RSVD
  } op_e;

  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC_LOAD, EXEC_MAC, EXEC_STORE, HALT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              stop_q, stop_d;
  op_e               ir_op_q;
  logic [23:0]       ir_base_q;

  logic              ir_load, issue, store_cyc, capture;
  logic              mac_mul, mac_acc, acc_clr, done;

  logic [DATA_W-1:0]   a_q    [LANES];
  logic [DATA_W-1:0]   b_q    [LANES];
  logic [ACC_W-1:0]    prod_q [LANES];
  logic [ACC_W-1:0]    acc_q  [LANES];
  logic [2*DATA_W-1:0] mul_full [LANES];

  logic [31:0]       addr_hold_q, din_hold_q;
  logic [31:0]       issue_addr, store_data;
  logic [23:0]       issue_word;
  logic [CNT_W-1:0]  cap_idx;
  op_e               fetch_op;
  logic              unused_bits;

  assign fetch_op    = op_e'(INSTR_AXI[2:0]);
  assign unused_bits = ^{INSTR_AXI[7:3], bram.doutb};

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    stop_d    = stop_q;
    ir_load   = 1'b0;
    issue     = 1'b0;
    store_cyc = 1'b0;
    capture   = 1'b0;
    mac_mul   = 1'b0;
    mac_acc   = 1'b0;
    acc_clr   = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: if (START_SIGNAL) begin
        pc_d    = '0;
        cnt_d   = '0;
        state_d = FETCH;
      end
      FETCH: if (cnt_q == '0) begin
        cnt_d = CNT_W'(1);
      end else begin
        ir_load = 1'b1;
        cnt_d   = '0;
        case (fetch_op)
          OP_LOADA, OP_LOADB: state_d = EXEC_LOAD;
          OP_STORE:           state_d = EXEC_STORE;
          OP_STOP: begin
            state_d = HALT;
            stop_d  = 1'b1;
          end
          default:            state_d = EXEC_MAC;
        endcase
      end
      EXEC_LOAD: begin
        issue   = (cnt_q < CNT_W'(LANES));
        capture = (cnt_q >= CNT_W'(BRAM_LAT));
        if (cnt_q == CNT_W'(LANES + BRAM_LAT - 1)) done = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      // NOP, CLR and the reserved opcode share this state as one-cycle ops.
      EXEC_MAC: if (ir_op_q == OP_MAC && cnt_q == '0) begin
        mac_mul = 1'b1;
        cnt_d   = CNT_W'(1);
      end else begin
        mac_acc = (ir_op_q == OP_MAC);
        acc_clr = (ir_op_q == OP_CLR);
        done    = 1'b1;
      end
      EXEC_STORE: begin
        issue     = 1'b1;
        store_cyc = 1'b1;
        if (cnt_q == CNT_W'(LANES - 1)) done = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      HALT: if (!START_SIGNAL) begin
        state_d = IDLE;
        stop_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = FETCH;
      cnt_d   = '0;
      pc_d    = (pc_q == PC_W'(N - 1)) ? '0 : pc_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      stop_q  <= stop_d;
    end
  end

  assign issue_word = ir_base_q + 24'(cnt_q);
  assign issue_addr = {6'd0, issue_word, 2'b00};
  assign cap_idx    = cnt_q - CNT_W'(BRAM_LAT);

  always_comb begin
    store_data = '0;
    for (int i = 0; i < LANES; i++) begin
      mul_full[i] = (2*DATA_W)'(a_q[i]) * (2*DATA_W)'(b_q[i]);
      if (cnt_q == CNT_W'(i)) store_data = acc_q[i][31:0];
    end
  end

  // NOTE: the lane register files are small and architecturally visible, so
  // they are reset explicitly rather than left as uninitialised storage.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ir_op_q     <= OP_NOP;
      ir_base_q   <= '0;
      addr_hold_q <= '0;
      din_hold_q  <= '0;
      for (int i = 0; i < LANES; i++) begin
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      if (ir_load) begin
        ir_op_q   <= fetch_op;
        ir_base_q <= INSTR_AXI[31:8];
      end
      if (issue)     addr_hold_q <= issue_addr;
      if (store_cyc) din_hold_q  <= store_data;
      for (int i = 0; i < LANES; i++) begin
        if (capture && cap_idx == CNT_W'(i)) begin
          if (ir_op_q == OP_LOADA) a_q[i] <= bram.doutb[DATA_W-1:0];
          else                     b_q[i] <= bram.doutb[DATA_W-1:0];
        end
        if (mac_mul) prod_q[i] <= ACC_W'(mul_full[i]);
        if (acc_clr)      acc_q[i] <= '0;
        else if (mac_acc) acc_q[i] <= acc_q[i] + prod_q[i];
      end
    end
  end

  // Bus outputs decode from state so reset assertion drops enb/web immediately.
  assign bram.enb   = issue;
  assign bram.web   = store_cyc ? 4'hF : 4'h0;
  assign bram.addrb = issue ? issue_addr : addr_hold_q;
  assign bram.dinb  = store_cyc ? store_data : din_hold_q;
  assign STOP_SIGNAL = stop_q;
  assign PC_AXI      = pc_q;
endmodule

// File: doc/simd_vec_engine.md
Name: simd_vec_engine

Overview:
- Parametrised successor to the fixed 2-lane PL SIMD core: an instruction-driven vector engine with LANES parallel lanes.
- Fetches 32-bit instructions by PC, loads A/B operand vectors from a BRAM port, performs lane-wise multiply-accumulate into wide accumulators, and stores results back to BRAM.
- Sits in the PL fabric behind the AXI instruction memory and the BRAM port B, started and stopped by GPIO.

Parameters:
- LANES, 4, number of parallel lanes (1..16).
- DATA_W, 32, operand width in bits, unsigned, taken from doutb[DATA_W-1:0] (8..32).
- ACC_W, 64, accumulator width in bits; accumulation wraps modulo 2^ACC_W.
- BRAM_LAT, 2, BRAM read latency in cycles (1..4).
- N, 512, instruction memory depth; PC width is clog2(N).

Ports:
- CLK, in, 1, clock; all flops rise-edge.
- RSTN, in, 1, reset; asynchronous, active-low.
- START_SIGNAL, in, 1, GPIO run request.
- STOP_SIGNAL, out, 1, GPIO halted flag.
- INSTR_AXI, in, 32, instruction word at PC_AXI.
- PC_AXI, out, clog2(N), program counter.
- addrb, out, 32, BRAM byte address = word_addr*4.
- dinb, out, 32, BRAM write data.
- doutb, in, 32, BRAM read data.
- enb, out, 1, BRAM enable.
- web, out, 4, BRAM byte write enables.

Behaviour:
- Instruction fields: op=INSTR[2:0], base=INSTR[31:8] (word address).
- Opcodes: 000 NOP, 001 CLR, 010 LOADA, 011 LOADB, 100 MAC, 101 STORE, 110 STOP. 111 behaves as NOP.
- Reset: all outputs 0 and all A/B/acc registers 0. State is IDLE, PC_AXI=0. enb/web drop immediately on reset assertion, including mid-operation.
- States: IDLE, FETCH, EXEC_LOAD, EXEC_MAC, EXEC_STORE, HALT.
- IDLE: when START_SIGNAL=1, set PC_AXI=0 and go to FETCH.
- FETCH: 2 cycles. PC_AXI is held; INSTR_AXI is captured into IR on the edge ending the 2nd cycle, then dispatch occurs.
  - NOP/CLR: 1 exec cycle. CLR zeroes all accumulators.
- LOADA/LOADB:
  - Cycles 0..LANES-1: enb=1, web=0, addrb=(base+i)*4.
  - Read i data is captured BRAM_LAT cycles after its issue into A[i] or B[i].
  - Total LANES+BRAM_LAT cycles; enb=0 during the drain.
- MAC: 2 cycles. Cycle 1 registers products A[i]*B[i] (2*DATA_W bits, zero-extended/truncated to ACC_W). Cycle 2 does acc[i] += product.
- STORE:
  - Cycles 0..LANES-1: enb=1, web=4'hF, addrb=(base+i)*4, dinb=acc[i][31:0].
  - Accumulators are not cleared.
- Completion: after each non-STOP instruction, PC_AXI increments (N-1 wraps to 0) and the FSM returns to FETCH.
- STOP: go to HALT and set STOP_SIGNAL=1. It stays 1 while START_SIGNAL=1. When START_SIGNAL=0, go to IDLE with STOP_SIGNAL=0 on the next cycle.
- START_SIGNAL is only examined in IDLE and HALT; deassertion mid-program is ignored.
- Outside load/store issue cycles: enb=0, web=0, addrb and dinb hold their last values.
- base+i wraps modulo 2^24.

Test Plan:
- LANES=2, BRAM_LAT=2, program LOADA base 2, LOADB base 3 -> addrb reads 8,12 then 12,16. With doutb returning 25,29 then 51,63: A=[25,29], B=[51,63].
- Continue with MAC, then STORE base 9 -> writes addrb=36 dinb=1275 and addrb=40 dinb=1827, web=4'hF exactly 2 cycles each.
- Second MAC then STORE -> 2550 and 3654. Then CLR, MAC, STORE -> 1275 and 1827 again.
- STOP at PC 5 -> STOP_SIGNAL=1 and PC_AXI frozen at 5. START_SIGNAL 1->0 -> STOP_SIGNAL=0 next cycle. Re-raising START -> PC_AXI=0.
- N=8, seven NOPs then NOP at PC 7 -> PC_AXI wraps to 0. DATA_W=32 with 0xFFFFFFFF*0xFFFFFFFF -> acc=0xFFFFFFFE00000001; stored low word is 0x00000001.
- Assert RSTN=0 during the 2nd load issue cycle -> enb=0 and web=0 asynchronously. All registers read 0 after release. STOP_SIGNAL=0 and state is IDLE.
